// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one external 16-bit combinational ALU between two requesters
// (req0 = execute stage, req1 = address/branch helper). One operation is in
// flight at a time: IDLE accepts a request, EXEC lets the ALU settle on the
// registered operands, RESP holds the captured result until it is consumed.
//
// Build option: define ALU_ARB_RR_EN for round-robin arbitration between the
// two requesters; leave it undefined for fixed priority (req0 wins a tie).
module alu_arbiter #(
    parameter int OPERAND_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [4:0]               req0_opcode,
    input  logic [1:0]               req0_funct,
    input  logic [OPERAND_WIDTH-1:0] req0_a,
    input  logic [OPERAND_WIDTH-1:0] req0_b,

    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic [4:0]               req1_opcode,
    input  logic [1:0]               req1_funct,
    input  logic [OPERAND_WIDTH-1:0] req1_a,
    input  logic [OPERAND_WIDTH-1:0] req1_b,

    output logic [4:0]               alu_opcode,
    output logic [1:0]               alu_funct,
    output logic [OPERAND_WIDTH-1:0] alu_a,
    output logic [OPERAND_WIDTH-1:0] alu_b,
    input  logic [OPERAND_WIDTH-1:0] alu_result,

    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic                     rsp_id,
    output logic [OPERAND_WIDTH-1:0] rsp_data
);

    localparam int OW = OPERAND_WIDTH;
    localparam int NREQ = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Requester channels gathered into arrays so arbitration and muxing
    // can index by requester id.
    logic [NREQ-1:0] req_valid;
    logic [4:0]      req_opcode [NREQ];
    logic [1:0]      req_funct  [NREQ];
    logic [OW-1:0]   req_a      [NREQ];
    logic [OW-1:0]   req_b      [NREQ];
    logic [NREQ-1:0] req_ready;

    assign req_valid     = {req1_valid, req0_valid};
    assign req_opcode[0] = req0_opcode;
    assign req_opcode[1] = req1_opcode;
    assign req_funct[0]  = req0_funct;
    assign req_funct[1]  = req1_funct;
    assign req_a[0]      = req0_a;
    assign req_a[1]      = req1_a;
    assign req_b[0]      = req0_b;
    assign req_b[1]      = req1_b;
    assign req0_ready    = req_ready[0];
    assign req1_ready    = req_ready[1];

    // State registers and their next-state values
    logic [1:0]    state_q, state_d;
    logic [4:0]    alu_opcode_q, alu_opcode_d;
    logic [1:0]    alu_funct_q, alu_funct_d;
    logic [OW-1:0] alu_a_q, alu_a_d;
    logic [OW-1:0] alu_b_q, alu_b_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_id_q, rsp_id_d;
    logic [OW-1:0] rsp_data_q, rsp_data_d;

    logic [NREQ-1:0] grant;
    logic            accept_any;
    logic            accept_id;

`ifdef ALU_ARB_RR_EN
    // Pointer names the requester preferred on a tie; it flips away from
    // whoever was just served so both sides make progress.
    logic ptr_q, ptr_d;

    // Round-robin grant: a lone requester always wins, a tie goes to ptr_q.
    always_comb begin
        grant = '0;
        if (&req_valid) begin
            grant[ptr_q] = 1'b1;
        end else begin
            grant = req_valid;
        end
    end

    // Pointer update on every accepted request.
    always_comb begin
        ptr_d = ptr_q;
        if (accept_any) begin
            ptr_d = ~accept_id;
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Fixed-priority grant: req0 wins whenever it is valid.
    always_comb begin
        grant    = '0;
        grant[0] = req_valid[0];
        grant[1] = req_valid[1] & ~req_valid[0];
    end
`endif

    // Ready is only offered while idle, and only to the granted requester.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
        assign req_ready[gi] = (state_q == ST_IDLE) & grant[gi];
    end

    assign accept_any = |req_ready;
    assign accept_id  = req_ready[1];

    // Next-state logic for the IDLE -> EXEC -> RESP -> IDLE sequence.
    always_comb begin
        state_d      = state_q;
        alu_opcode_d = alu_opcode_q;
        alu_funct_d  = alu_funct_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        case (state_q)
            ST_IDLE: begin
                // ALU inputs only change on an accept, so the ALU sees the
                // previous operation's operands while nothing is pending.
                if (accept_any) begin
                    alu_opcode_d = req_opcode[accept_id];
                    alu_funct_d  = req_funct[accept_id];
                    alu_a_d      = req_a[accept_id];
                    alu_b_d      = req_b[accept_id];
                    rsp_id_d     = accept_id;
                    state_d      = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // ALU has had a full cycle on registered inputs; sample it.
                rsp_data_d  = alu_result;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // Registered state; reset drops any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            alu_opcode_q <= '0;
            alu_funct_q  <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            alu_opcode_q <= alu_opcode_d;
            alu_funct_q  <= alu_funct_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    assign alu_opcode = alu_opcode_q;
    assign alu_funct  = alu_funct_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_data   = rsp_data_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: a small ALU model closes the loop on the
// alu_* port; a negedge monitor predicts grants and responses and checks them
// against a scoreboard queue filled at each observed accept.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [4:0]  req0_opcode = '0, req1_opcode = '0;
    logic [1:0]  req0_funct = '0, req1_funct = '0;
    logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [4:0]  alu_opcode;
    logic [1:0]  alu_funct;
    logic [15:0] alu_a, alu_b, alu_result;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_id;
    logic [15:0] rsp_data;

    always #5 clk = ~clk;

    alu_arbiter #(.OPERAND_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
        .req0_funct(req0_funct), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
        .req1_funct(req1_funct), .req1_a(req1_a), .req1_b(req1_b),
        .alu_opcode(alu_opcode), .alu_funct(alu_funct), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data)
    );

    // Behavioural ALU: every field influences the result.
    function automatic logic [15:0] alu_fn(input logic [4:0] op, input logic [1:0] f,
                                           input logic [15:0] a, input logic [15:0] b);
        case (op)
            5'b01000: return a + b;
            5'b10010: return {a[7:0], b[7:0]};
            5'b11011: begin
                case (f)
                    2'b00:   return a + b;
                    2'b01:   return b - a;
                    2'b10:   return a ^ b;
                    default: return a & b;
                endcase
            end
            default: return (a ^ {b[7:0], b[15:8]}) + {9'd0, op, f};
        endcase
    endfunction

    assign alu_result = alu_fn(alu_opcode, alu_funct, alu_a, alu_b);

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Response consumer: 0 = always ready, 1 = random, 2 = stalled.
    int rsp_mode = 0;
    always @(posedge clk) begin
        #1;
        case (rsp_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = 1'($urandom_range(0, 1));
            default: rsp_ready = 1'b0;
        endcase
    end

    typedef struct {
        logic        id;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];
    bit   acc_log[$];
    int   cyc = 0;
    int   acc_cyc = 0;
    bit   busy = 1'b0;
    bit   ptr_m = 1'b0;
    bit   prev_v = 1'b0;
    bit   prev_r = 1'b0;

    // Monitor: reference model of arbitration and the one-op-in-flight protocol.
    always @(negedge clk) begin
        bit   busy_start;
        bit   g;
        exp_t e;
        cyc++;
        if (rst) begin
            sb.delete();
            busy   = 1'b0;
            ptr_m  = 1'b0;
            prev_v = 1'b0;
            prev_r = 1'b0;
        end else begin
            busy_start = busy;
            if (req0_ready || req1_ready)
                chk_eq("ready_onehot", {31'd0, req0_ready & req1_ready}, 0);
            if (busy_start) begin
                chk_eq("ready_while_busy", {31'd0, req0_ready | req1_ready}, 0);
                if (cyc == acc_cyc + 2) chk_eq("rsp_latency", {31'd0, rsp_valid}, 1);
                if (cyc < acc_cyc + 2) chk_eq("rsp_early", {31'd0, rsp_valid}, 0);
            end else begin
                chk_eq("rsp_valid_idle", {31'd0, rsp_valid}, 0);
            end
            if (rsp_valid && busy_start && sb.size() > 0) begin
                e = sb[0];
                chk_eq("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
                chk_eq("rsp_data", {16'd0, rsp_data}, {16'd0, e.data});
                if (rsp_ready) begin
                    $display("rsp id=%0d data=%h (expected id=%0d data=%h) cyc=%0d",
                             rsp_id, rsp_data, e.id, e.data, cyc);
                    void'(sb.pop_front());
                    busy = 1'b0;
                end
            end else if (!rsp_valid && prev_v && !prev_r) begin
                chk_eq("rsp_dropped", {31'd0, rsp_valid}, 1);
            end
            prev_v = rsp_valid;
            prev_r = rsp_ready;
            if (!busy_start && (req0_valid || req1_valid)) begin
                g = (req0_valid && req1_valid) ? ptr_m : !req0_valid;
                chk_eq("grant_taken",
                       {31'd0, (req0_valid & req0_ready) | (req1_valid & req1_ready)}, 1);
                chk_eq("grant_id", {31'd0, req1_ready}, {31'd0, g});
                e.id   = g;
                e.data = g ? alu_fn(req1_opcode, req1_funct, req1_a, req1_b)
                           : alu_fn(req0_opcode, req0_funct, req0_a, req0_b);
                sb.push_back(e);
                acc_log.push_back(g);
                busy    = 1'b1;
                acc_cyc = cyc;
`ifdef ALU_ARB_RR_EN
                ptr_m = ~g;
`endif
            end
        end
    end

    // Present one op on a requester and hold it until accepted.
    task automatic issue(input bit id, input logic [4:0] op, input logic [1:0] f,
                         input logic [15:0] a, input logic [15:0] b);
        int n = 0;
        if (id == 1'b0) begin
            req0_valid = 1'b1; req0_opcode = op; req0_funct = f; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_opcode = op; req1_funct = f; req1_a = a; req1_b = b;
        end
        forever begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) break;
            n++;
            if (n > 300) begin
                chk_eq("issue_timeout", n, 0);
                break;
            end
        end
        @(posedge clk);
        #1;
        if (id == 1'b0) req0_valid = 1'b0;
        else            req1_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || sb.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk_eq("idle_timeout", n, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rsp(input string name, input bit id, input logic [15:0] data);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 50);
        chk_eq({name, "_id"}, {31'd0, rsp_id}, {31'd0, id});
        chk_eq({name, "_data"}, {16'd0, rsp_data}, {16'd0, data});
    endtask

    initial begin
        int          base;
        int          sel;
        logic [15:0] held;
        bit          exp_id;

        rsp_mode = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_eq("reset_rsp_valid", {31'd0, rsp_valid}, 0);
        chk_eq("reset_rsp_id", {31'd0, rsp_id}, 0);
        chk_eq("reset_rsp_data", {16'd0, rsp_data}, 0);
        chk_eq("reset_alu", {9'd0, alu_opcode, alu_funct, alu_a}, 0);
        chk_eq("reset_alu_b", {16'd0, alu_b}, 0);
        @(posedge clk);
        #1;

        // ADDI through req0, then a new op must be accepted right after.
        issue(1'b0, 5'b01000, 2'b00, 16'h0003, 16'h0004);
        expect_rsp("addi", 1'b0, 16'h0007);
        @(posedge clk);
        #1 req0_valid = 1'b1;
        @(negedge clk);
        chk_eq("ready_after_rsp", {31'd0, req0_ready}, 1);
        @(posedge clk);
        #1 req0_valid = 1'b0;
        wait_idle();

        // SUB through req1.
        issue(1'b1, 5'b11011, 2'b01, 16'h0005, 16'h0009);
        expect_rsp("sub", 1'b1, 16'h0004);
        wait_idle();

        // SLBI through req0.
        issue(1'b0, 5'b10010, 2'b00, 16'h00AB, 16'h00CD);
        expect_rsp("slbi", 1'b0, 16'hABCD);
        wait_idle();

        // Stalled consumer: response held, nobody accepted.
        rsp_mode = 2;
        issue(1'b0, 5'b00111, 2'b10, 16'h1234, 16'h5678);
        expect_rsp("stall", 1'b0, alu_fn(5'b00111, 2'b10, 16'h1234, 16'h5678));
        held = rsp_data;
        @(posedge clk);
        #1;
        req1_opcode = 5'b01000; req1_funct = 2'b00; req1_a = 16'h0100; req1_b = 16'h0011;
        req1_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk_eq("stall_valid", {31'd0, rsp_valid}, 1);
            chk_eq("stall_data", {16'd0, rsp_data}, {16'd0, held});
            chk_eq("stall_ready", {30'd0, req1_ready, req0_ready}, 0);
        end
        rsp_mode = 0;
        @(negedge clk);
        @(negedge clk);
        chk_eq("release_valid_low", {31'd0, rsp_valid}, 0);
        chk_eq("release_req1_ready", {31'd0, req1_ready}, 1);
        @(posedge clk);
        #1 req1_valid = 1'b0;
        wait_idle();

        // Reset while the op is in EXEC: it vanishes.
        issue(1'b0, 5'b01000, 2'b00, 16'h7777, 16'h1111);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_eq("midrst_rsp_valid", {31'd0, rsp_valid}, 0);
        chk_eq("midrst_alu", {9'd0, alu_opcode, alu_funct, alu_a}, 0);
        chk_eq("midrst_alu_b", {16'd0, alu_b}, 0);
        repeat (3) begin
            @(negedge clk);
            chk_eq("midrst_no_rsp", {31'd0, rsp_valid}, 0);
        end
        @(posedge clk);
        #1;
        base = acc_log.size();
        fork
            issue(1'b0, 5'b01000, 2'b00, 16'h0001, 16'h0002);
            issue(1'b1, 5'b01000, 2'b00, 16'h0010, 16'h0020);
        join
        wait_idle();
        chk_eq("post_rst_first_grant", {31'd0, acc_log[base]}, 0);

        // Both requesters busy for several ops.
        base = acc_log.size();
        fork
            for (int k = 0; k < 4; k++)
                issue(1'b0, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
                      16'($urandom), 16'($urandom));
            for (int k = 0; k < 4; k++)
                issue(1'b1, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
                      16'($urandom), 16'($urandom));
        join
        wait_idle();
        for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_RR_EN
            exp_id = k[0];
`else
            exp_id = 1'b0;
`endif
            chk_eq("contend_order", {31'd0, acc_log[base + k]}, {31'd0, exp_id});
        end

        // Random traffic with a random consumer.
        rsp_mode = 1;
        for (int it = 0; it < 40; it++) begin
            sel = $urandom_range(1, 3);
            fork
                if (sel[0])
                    issue(1'b0, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
                          16'($urandom), 16'($urandom));
                if (sel[1])
                    issue(1'b1, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
                          16'($urandom), 16'($urandom));
            join
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        wait_idle();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
